// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
//   Holds ALU-class instructions from the decoder until both source operands
//   are resolved, snooping the ALU and load result broadcasts, and dispatches
//   one ready instruction per cycle to the ALU.
//
//   Optional build macro RS_AGE_SELECT_EN: when defined, every entry carries
//   an issue-order stamp and dispatch picks the oldest ready entry; when
//   undefined, dispatch picks the lowest-index ready entry.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global ready, low stalls everything
//   clr                      misprediction flush
//   issue_*                  decoder issue port (rs_enable selects this RS)
//   alu_result_*             ALU result broadcast
//   lsb_load_result_*        load result broadcast
//   rs_full                  to ifetch, high when at most one entry is free
//   alu_*                    registered dispatch to the ALU
// -----------------------------------------------------------------------------
module reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 5,
    parameter int OPENUM_W  = 6,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 issue_enable,
    input  logic                 rs_enable,
    input  logic [OPENUM_W-1:0]  issue_openum,
    input  logic [DATA_W-1:0]    issue_rs1_val,
    input  logic [ROB_POS_W-1:0] issue_rs1_rob_pos,
    input  logic [DATA_W-1:0]    issue_rs2_val,
    input  logic [ROB_POS_W-1:0] issue_rs2_rob_pos,
    input  logic [DATA_W-1:0]    issue_imm,
    input  logic [DATA_W-1:0]    issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic                 alu_result_ready,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [DATA_W-1:0]    alu_result_val,
    input  logic                 lsb_load_result_ready,
    input  logic [ROB_POS_W-1:0] lsb_load_result_rob_pos,
    input  logic [DATA_W-1:0]    lsb_load_result_val,
    output logic                 rs_full,
    output logic                 alu_enable,
    output logic [OPENUM_W-1:0]  alu_openum,
    output logic [DATA_W-1:0]    alu_val1,
    output logic [DATA_W-1:0]    alu_val2,
    output logic [DATA_W-1:0]    alu_imm,
    output logic [DATA_W-1:0]    alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]   busy;
    logic [OPENUM_W-1:0]  e_openum  [RS_SIZE];
    logic [DATA_W-1:0]    e_val1    [RS_SIZE];
    logic [DATA_W-1:0]    e_val2    [RS_SIZE];
    logic [ROB_POS_W-1:0] e_tag1    [RS_SIZE];
    logic [ROB_POS_W-1:0] e_tag2    [RS_SIZE];
    logic [DATA_W-1:0]    e_imm     [RS_SIZE];
    logic [DATA_W-1:0]    e_pc      [RS_SIZE];
    logic [ROB_POS_W-1:0] e_rob_pos [RS_SIZE];

`ifdef RS_AGE_SELECT_EN
    // One bit wider than the index so that, with at most RS_SIZE entries in
    // flight, the wrapped difference of two stamps is always unambiguous.
    logic [CNT_W-1:0]     e_age     [RS_SIZE];
    logic [CNT_W-1:0]     age_ctr;

    function automatic logic is_older(input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] diff;
        diff = b - a;
        return (diff != '0) && !diff[CNT_W-1];
    endfunction
`endif

    logic [RS_SIZE-1:0]   ready;
    logic [CNT_W-1:0]     free_cnt;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 disp_found;
    logic [IDX_W-1:0]     disp_idx;
    logic                 do_write;
    logic [DATA_W-1:0]    in_val1;
    logic [DATA_W-1:0]    in_val2;
    logic [ROB_POS_W-1:0] in_tag1;
    logic [ROB_POS_W-1:0] in_tag2;

    always_comb begin
        ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (e_tag1[i] == '0) && (e_tag2[i] == '0);
        end
    end

    // Free slot search runs on the current busy bits, so a slot released by
    // dispatch at this edge is not a write target until the next cycle.
    always_comb begin
        free_cnt   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_cnt   = free_cnt + CNT_W'(1);
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // rs_full leaves room for one instruction already in flight from fetch.
    assign rs_full = (free_cnt <= CNT_W'(1));

    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
`ifdef RS_AGE_SELECT_EN
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!disp_found || is_older(e_age[i], e_age[disp_idx]))) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
        end
`else
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
        end
`endif
    end

    // Write-time snoop: a broadcast in the same cycle as the issue would
    // otherwise be missed, since the new entry is not yet busy.
    always_comb begin
        in_val1 = issue_rs1_val;
        in_tag1 = issue_rs1_rob_pos;
        in_val2 = issue_rs2_val;
        in_tag2 = issue_rs2_rob_pos;
        if (issue_rs1_rob_pos != '0) begin
            if (alu_result_ready && (alu_result_rob_pos == issue_rs1_rob_pos)) begin
                in_val1 = alu_result_val;
                in_tag1 = '0;
            end else if (lsb_load_result_ready && (lsb_load_result_rob_pos == issue_rs1_rob_pos)) begin
                in_val1 = lsb_load_result_val;
                in_tag1 = '0;
            end
        end
        if (issue_rs2_rob_pos != '0) begin
            if (alu_result_ready && (alu_result_rob_pos == issue_rs2_rob_pos)) begin
                in_val2 = alu_result_val;
                in_tag2 = '0;
            end else if (lsb_load_result_ready && (lsb_load_result_rob_pos == issue_rs2_rob_pos)) begin
                in_val2 = lsb_load_result_val;
                in_tag2 = '0;
            end
        end
    end

    assign do_write = issue_enable && rs_enable && free_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            alu_enable  <= 1'b0;
            alu_openum  <= '0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
`ifdef RS_AGE_SELECT_EN
            age_ctr     <= '0;
`endif
        end else if (!rdy) begin
            alu_enable <= 1'b0;
        end else if (clr) begin
            busy       <= '0;
            alu_enable <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (e_tag1[i] != '0) begin
                        if (alu_result_ready && (alu_result_rob_pos == e_tag1[i])) begin
                            e_val1[i] <= alu_result_val;
                            e_tag1[i] <= '0;
                        end else if (lsb_load_result_ready && (lsb_load_result_rob_pos == e_tag1[i])) begin
                            e_val1[i] <= lsb_load_result_val;
                            e_tag1[i] <= '0;
                        end
                    end
                    if (e_tag2[i] != '0) begin
                        if (alu_result_ready && (alu_result_rob_pos == e_tag2[i])) begin
                            e_val2[i] <= alu_result_val;
                            e_tag2[i] <= '0;
                        end else if (lsb_load_result_ready && (lsb_load_result_rob_pos == e_tag2[i])) begin
                            e_val2[i] <= lsb_load_result_val;
                            e_tag2[i] <= '0;
                        end
                    end
                end
            end

            if (disp_found) begin
                alu_enable       <= 1'b1;
                alu_openum       <= e_openum[disp_idx];
                alu_val1         <= e_val1[disp_idx];
                alu_val2         <= e_val2[disp_idx];
                alu_imm          <= e_imm[disp_idx];
                alu_pc           <= e_pc[disp_idx];
                alu_rob_pos      <= e_rob_pos[disp_idx];
                busy[disp_idx]   <= 1'b0;
            end else begin
                alu_enable <= 1'b0;
            end

            if (do_write) begin
                busy[free_idx]      <= 1'b1;
                e_openum[free_idx]  <= issue_openum;
                e_val1[free_idx]    <= in_val1;
                e_tag1[free_idx]    <= in_tag1;
                e_val2[free_idx]    <= in_val2;
                e_tag2[free_idx]    <= in_tag2;
                e_imm[free_idx]     <= issue_imm;
                e_pc[free_idx]      <= issue_pc;
                e_rob_pos[free_idx] <= issue_rob_pos;
`ifdef RS_AGE_SELECT_EN
                e_age[free_idx]     <= age_ctr;
                age_ctr             <= age_ctr + CNT_W'(1);
`endif
            end
        end
    end

    // Fetch must honour rs_full; an issue with no free entry is dropped.
    issue_while_full_a: assert property (@(posedge clk) disable iff (rst)
        !(rdy && !clr && issue_enable && rs_enable && (free_cnt == '0)));

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

    localparam int RS = 16;

    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        issue_enable, rs_enable;
    logic [5:0]  issue_openum;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
    logic [4:0]  issue_rs1_rob_pos, issue_rs2_rob_pos, issue_rob_pos;
    logic        alu_result_ready, lsb_load_result_ready;
    logic [4:0]  alu_result_rob_pos, lsb_load_result_rob_pos;
    logic [31:0] alu_result_val, lsb_load_result_val;
    logic        rs_full, alu_enable;
    logic [5:0]  alu_openum;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [4:0]  alu_rob_pos;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .issue_enable(issue_enable), .rs_enable(rs_enable),
        .issue_openum(issue_openum),
        .issue_rs1_val(issue_rs1_val), .issue_rs1_rob_pos(issue_rs1_rob_pos),
        .issue_rs2_val(issue_rs2_val), .issue_rs2_rob_pos(issue_rs2_rob_pos),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos),
        .alu_result_ready(alu_result_ready), .alu_result_rob_pos(alu_result_rob_pos),
        .alu_result_val(alu_result_val),
        .lsb_load_result_ready(lsb_load_result_ready),
        .lsb_load_result_rob_pos(lsb_load_result_rob_pos),
        .lsb_load_result_val(lsb_load_result_val),
        .rs_full(rs_full), .alu_enable(alu_enable), .alu_openum(alu_openum),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [4:0]  t1, t2, rob;
        int unsigned seq;
    } ent_t;

    ent_t        m [RS];
    int unsigned seq_ctr;
    logic        exp_en;
    logic [5:0]  exp_op;
    logic [31:0] exp_v1, exp_v2, exp_imm, exp_pc;
    logic [4:0]  exp_rob;

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < RS; i++) if (!m[i].busy) n++;
        return n;
    endfunction

    // Returns {tag, value} after applying whatever broadcast is visible now.
    function automatic logic [36:0] snoop(input logic [4:0] t, input logic [31:0] v);
        if (t != 0 && alu_result_ready && alu_result_rob_pos == t) return {5'd0, alu_result_val};
        if (t != 0 && lsb_load_result_ready && lsb_load_result_rob_pos == t) return {5'd0, lsb_load_result_val};
        return {t, v};
    endfunction

    task automatic model_step();
        int sel, wr;
        if (rst) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            seq_ctr = 0;
            exp_en = 0; exp_op = 0; exp_v1 = 0; exp_v2 = 0;
            exp_imm = 0; exp_pc = 0; exp_rob = 0;
        end else if (!rdy) begin
            exp_en = 0;
        end else if (clr) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            exp_en = 0;
        end else begin
            sel = -1;
            for (int i = 0; i < RS; i++) begin
                if (m[i].busy && m[i].t1 == 0 && m[i].t2 == 0) begin
`ifdef RS_AGE_SELECT_EN
                    if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
                    if (sel < 0) sel = i;
`endif
                end
            end
            wr = -1;
            for (int i = 0; i < RS; i++) if (!m[i].busy && wr < 0) wr = i;
            if (sel >= 0) begin
                exp_en = 1; exp_op = m[sel].op; exp_v1 = m[sel].v1; exp_v2 = m[sel].v2;
                exp_imm = m[sel].imm; exp_pc = m[sel].pc; exp_rob = m[sel].rob;
            end else begin
                exp_en = 0;
            end
            for (int i = 0; i < RS; i++) begin
                if (m[i].busy) begin
                    {m[i].t1, m[i].v1} = snoop(m[i].t1, m[i].v1);
                    {m[i].t2, m[i].v2} = snoop(m[i].t2, m[i].v2);
                end
            end
            if (sel >= 0) m[sel].busy = 0;
            if (issue_enable && rs_enable && wr >= 0) begin
                m[wr].busy = 1; m[wr].op = issue_openum;
                {m[wr].t1, m[wr].v1} = snoop(issue_rs1_rob_pos, issue_rs1_val);
                {m[wr].t2, m[wr].v2} = snoop(issue_rs2_rob_pos, issue_rs2_val);
                m[wr].imm = issue_imm; m[wr].pc = issue_pc; m[wr].rob = issue_rob_pos;
                m[wr].seq = seq_ctr; seq_ctr++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("alu_enable", 64'(alu_enable), 64'(exp_en));
        chk("rs_full", 64'(rs_full), 64'(model_free() <= 1));
        chk("alu_openum", 64'(alu_openum), 64'(exp_op));
        chk("alu_val1", 64'(alu_val1), 64'(exp_v1));
        chk("alu_val2", 64'(alu_val2), 64'(exp_v2));
        chk("alu_imm", 64'(alu_imm), 64'(exp_imm));
        chk("alu_pc", 64'(alu_pc), 64'(exp_pc));
        chk("alu_rob_pos", 64'(alu_rob_pos), 64'(exp_rob));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        issue_enable = 0; rs_enable = 0;
        alu_result_ready = 0; lsb_load_result_ready = 0;
        rdy = 1; clr = 0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [4:0] t1,
                         input logic [31:0] v2, input logic [4:0] t2, input logic [4:0] rob);
        issue_enable = 1; rs_enable = 1; issue_openum = op;
        issue_rs1_val = v1; issue_rs1_rob_pos = t1;
        issue_rs2_val = v2; issue_rs2_rob_pos = t2;
        issue_imm = 32'h100 + 32'(rob); issue_pc = 32'h4000 + 32'(rob) * 4;
        issue_rob_pos = rob;
    endtask

    task automatic alu_bc(input logic [4:0] t, input logic [31:0] v);
        alu_result_ready = 1; alu_result_rob_pos = t; alu_result_val = v;
    endtask

    task automatic lsb_bc(input logic [4:0] t, input logic [31:0] v);
        lsb_load_result_ready = 1; lsb_load_result_rob_pos = t; lsb_load_result_val = v;
    endtask

    initial begin
        rst = 1; idle();
        issue_openum = 0; issue_rs1_val = 0; issue_rs1_rob_pos = 0;
        issue_rs2_val = 0; issue_rs2_rob_pos = 0; issue_imm = 0; issue_pc = 0;
        issue_rob_pos = 0; alu_result_rob_pos = 0; alu_result_val = 0;
        lsb_load_result_rob_pos = 0; lsb_load_result_val = 0;
        seq_ctr = 0;
        for (int i = 0; i < RS; i++) m[i] = '{busy: 0, op: 0, v1: 0, v2: 0, imm: 0, pc: 0, t1: 0, t2: 0, rob: 0, seq: 0};

        cycle(); cycle();
        chk("reset_enable", 64'(alu_enable), 64'd0);
        chk("reset_full", 64'(rs_full), 64'd0);
        rst = 0;
        cycle();

        // Ready ADD: written at edge k, dispatched at k+1.
        issue(6'd1, 32'd5, 5'd0, 32'd7, 5'd0, 5'd3);
        cycle(); idle();
        chk("add_not_yet", 64'(alu_enable), 64'd0);
        cycle();
        chk("add_en", 64'(alu_enable), 64'd1);
        chk("add_val1", 64'(alu_val1), 64'd5);
        chk("add_val2", 64'(alu_val2), 64'd7);
        chk("add_rob", 64'(alu_rob_pos), 64'd3);
        cycle();
        chk("add_en_drop", 64'(alu_enable), 64'd0);

        // Wakeup from ALU broadcast.
        issue(6'd2, 32'd0, 5'd2, 32'd1, 5'd0, 5'd4);
        cycle(); idle(); cycle();
        chk("sub_wait", 64'(alu_enable), 64'd0);
        alu_bc(5'd2, 32'h10);
        cycle(); idle();
        chk("sub_wake_edge", 64'(alu_enable), 64'd0);
        cycle();
        chk("sub_en", 64'(alu_enable), 64'd1);
        chk("sub_val1", 64'(alu_val1), 64'h10);

        // Write-time snoop of a load broadcast.
        issue(6'd3, 32'd9, 5'd0, 32'd0, 5'd6, 5'd5);
        lsb_bc(5'd6, 32'hAB);
        cycle(); idle(); cycle();
        chk("snoop_en", 64'(alu_enable), 64'd1);
        chk("snoop_val2", 64'(alu_val2), 64'hAB);
        cycle();

        // Fill 15 entries, each waiting on its own tag.
        for (int i = 0; i < 15; i++) begin
            issue(6'd4, 32'd0, 5'(10 + i), 32'(i), 5'd0, 5'(10 + i));
            cycle();
            if (i == 13) chk("fill14_full", 64'(rs_full), 64'd0);
        end
        idle();
        chk("fill15_full", 64'(rs_full), 64'd1);
        alu_bc(5'd10, 32'h55);
        cycle(); idle(); cycle();
        chk("drain_en", 64'(alu_enable), 64'd1);
        chk("drain_rob", 64'(alu_rob_pos), 64'd10);
        chk("drain_full", 64'(rs_full), 64'd0);
        for (int t = 11; t < 25; t++) begin
            alu_bc(5'(t), 32'(t * 3));
            cycle();
        end
        idle();
        repeat (3) cycle();

        // Flush with pending entries.
        for (int i = 0; i < 5; i++) begin
            issue(6'd5, 32'd0, 5'(25 + i), 32'd0, 5'd0, 5'(20 + i));
            cycle();
        end
        idle(); clr = 1;
        cycle(); clr = 0;
        chk("clr_en", 64'(alu_enable), 64'd0);
        chk("clr_full", 64'(rs_full), 64'd0);
        issue(6'd6, 32'd1, 5'd0, 32'd2, 5'd0, 5'd7);
        cycle(); idle(); cycle();
        chk("post_clr_en", 64'(alu_enable), 64'd1);
        chk("post_clr_rob", 64'(alu_rob_pos), 64'd7);
        cycle();
        chk("post_clr_no_stale", 64'(alu_enable), 64'd0);
        cycle();

        // Stall with two ready entries: idx0 is newer than idx1.
        issue(6'd7, 32'd0, 5'd30, 32'd0, 5'd0, 5'd10);
        cycle();
        issue(6'd7, 32'd0, 5'd3, 32'd0, 5'd0, 5'd11);
        cycle(); idle();
        alu_bc(5'd30, 32'h30);
        cycle(); idle(); cycle();
        chk("stall_pre_rob", 64'(alu_rob_pos), 64'd10);
        issue(6'd8, 32'd4, 5'd0, 32'd5, 5'd0, 5'd12);
        lsb_bc(5'd3, 32'h33);
        cycle();
        issue_enable = 0; rs_enable = 0; rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_en", 64'(alu_enable), 64'd0);
        end
        idle();
        cycle();
        chk("resume_en", 64'(alu_enable), 64'd1);
`ifdef RS_AGE_SELECT_EN
        chk("resume_first", 64'(alu_rob_pos), 64'd11);
        chk("resume_first_val1", 64'(alu_val1), 64'h33);
`else
        chk("resume_first", 64'(alu_rob_pos), 64'd12);
`endif
        cycle();
`ifdef RS_AGE_SELECT_EN
        chk("resume_second", 64'(alu_rob_pos), 64'd12);
`else
        chk("resume_second", 64'(alu_rob_pos), 64'd11);
        chk("resume_second_val1", 64'(alu_val1), 64'h33);
`endif
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 79) == 0);
            rs_enable = ($urandom_range(0, 7) != 0);
            issue_enable = ($urandom_range(0, 2) != 0) && (model_free() > 0);
            issue_openum = 6'($urandom);
            issue_rs1_val = $urandom; issue_rs2_val = $urandom;
            issue_rs1_rob_pos = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            issue_rs2_rob_pos = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            issue_imm = $urandom; issue_pc = $urandom;
            issue_rob_pos = 5'($urandom_range(1, 31));
            alu_result_ready = ($urandom_range(0, 1) != 0);
            alu_result_rob_pos = 5'($urandom_range(1, 7));
            alu_result_val = $urandom;
            lsb_load_result_ready = ($urandom_range(0, 1) != 0);
            lsb_load_result_rob_pos = 5'($urandom_range(1, 7));
            lsb_load_result_val = $urandom;
            cycle();
        end
        idle();
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
